// File: rtl/scfifo_s_showahead_if.sv
// scfifo_s_showahead_if: handshake/status bundle between a show-ahead FIFO
// and its user. The master drives data and requests. The slave (the FIFO)
// drives the head word and the status flags.
// When SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN is defined, the bundle also carries
// the sticky overflow/underflow outputs.
interface scfifo_s_showahead_if #(
  parameter int WIDTH     = 16,
  parameter int LOG_DEPTH = 4
);
  logic [WIDTH-1:0]     data;
  logic                 wrreq;
  logic                 rdreq;
  logic [WIDTH-1:0]     q;
  logic [LOG_DEPTH-1:0] usedw;
  logic                 empty;
  logic                 full;
  logic                 almost_empty;
  logic                 almost_full;
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
  logic                 overflow;
  logic                 underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );
  modport slave (
    input  data, wrreq, rdreq,
    output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );
`else
  modport master (
    output data, wrreq, rdreq,
    input  q, usedw, empty, full, almost_empty, almost_full
  );
  modport slave (
    input  data, wrreq, rdreq,
    output q, usedw, empty, full, almost_empty, almost_full
  );
`endif
endinterface

// File: rtl/scfifo_s_showahead.sv
// scfifo_s_showahead: single-clock first-word-fall-through FIFO.
// The storage array has a synchronous read port. A two-stage prefetch
// (memory read register p1, then output register p2) hides that read latency,
// so the head word sits on q whenever empty is low. usedw counts every
// accepted word that has not been popped, including words still in flight
// in p1/p2.
// Optional feature: define SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN to add the sticky
// overflow/underflow outputs.
module scfifo_s_showahead #(
  parameter int WIDTH              = 16,
  parameter int LOG_DEPTH          = 4,
  parameter int NUM_WORDS          = 2**LOG_DEPTH - 1,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic                clock,
  input  logic                aclr_n,
  input  logic                sclr,
  scfifo_s_showahead_if.slave fif
);
  localparam int DEPTH = 2**LOG_DEPTH;
  typedef logic [LOG_DEPTH-1:0] ptr_t;

  if (LOG_DEPTH < 3 || LOG_DEPTH > 10) begin : g_bad_log_depth
    $error("scfifo_s_showahead: LOG_DEPTH must be in 3..10");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > DEPTH - 1) begin : g_bad_num_words
    $error("scfifo_s_showahead: NUM_WORDS must be in 1..2**LOG_DEPTH-1");
  end
  if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > NUM_WORDS) begin : g_bad_af
    $error("scfifo_s_showahead: ALMOST_FULL_VALUE must be in 1..NUM_WORDS");
  end
  if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > NUM_WORDS) begin : g_bad_ae
    $error("scfifo_s_showahead: ALMOST_EMPTY_VALUE must be in 1..NUM_WORDS");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             arr_cnt_q, arr_cnt_d;   // words still held in the array
  ptr_t             usedw_q, usedw_d;
  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] data_p1_q;
  logic [WIDTH-1:0] data_p2_q, data_p2_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             aempty_q, aempty_d;
  logic             afull_q, afull_d;
  logic             acc_wr, acc_rd, take_p2, fetch, mem_we;
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
`endif

  // Accept decisions, prefetch movement, occupancy and flag next-state
  always_comb begin
    acc_wr    = fif.wrreq & ~full_q;
    acc_rd    = fif.rdreq & ~empty_q;
    // p1 -> p2 when p2 is vacant or its word is being popped this edge
    take_p2   = vld_p1_q & (~vld_p2_q | acc_rd);
    // array -> p1 when p1 is vacant or is draining into p2 this edge
    fetch     = (arr_cnt_q != '0) & (~vld_p1_q | take_p2);
    mem_we    = acc_wr & ~sclr;
    wr_ptr_d  = wr_ptr_q + ptr_t'(acc_wr);
    rd_ptr_d  = rd_ptr_q + ptr_t'(fetch);
    arr_cnt_d = arr_cnt_q + ptr_t'(acc_wr) - ptr_t'(fetch);
    usedw_d   = usedw_q + ptr_t'(acc_wr) - ptr_t'(acc_rd);
    vld_p1_d  = fetch | (vld_p1_q & ~take_p2);
    vld_p2_d  = take_p2 | (vld_p2_q & ~acc_rd);
    data_p2_d = take_p2 ? data_p1_q : data_p2_q;
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
    overflow_d  = overflow_q | (fif.wrreq & full_q);
    underflow_d = underflow_q | (fif.rdreq & empty_q);
`endif
    if (sclr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      arr_cnt_d = '0;
      usedw_d   = '0;
      vld_p1_d  = 1'b0;
      vld_p2_d  = 1'b0;
      data_p2_d = '0;
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`endif
    end
    // Flags follow the next usedw so they line up with the registered count
    empty_d  = ~vld_p2_d;
    full_d   = (usedw_d == ptr_t'(NUM_WORDS));
    afull_d  = (usedw_d >= ptr_t'(ALMOST_FULL_VALUE));
    aempty_d = (usedw_d < ptr_t'(ALMOST_EMPTY_VALUE));
  end

  // ---- stage p1 boundary: array write and synchronous read into p1 ----
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr_q] <= fif.data;
    if (fetch)  data_p1_q <= mem[rd_ptr_q];
  end

  // ---- stage p2 boundary: control state, output register and flags ----
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      arr_cnt_q <= '0;
      usedw_q   <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      aempty_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      arr_cnt_q <= arr_cnt_d;
      usedw_q   <= usedw_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      aempty_q  <= aempty_d;
      afull_q   <= afull_d;
    end
  end

`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
  // Sticky error flags, cleared only by aclr_n or sclr
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fif.overflow  = overflow_q;
  assign fif.underflow = underflow_q;
`endif

  assign fif.q            = data_p2_q;
  assign fif.usedw        = usedw_q;
  assign fif.empty        = empty_q;
  assign fif.full         = full_q;
  assign fif.almost_empty = aempty_q;
  assign fif.almost_full  = afull_q;
endmodule

// File: tb/tb_scfifo_s_showahead.sv
// Directed bench for scfifo_s_showahead with a scoreboard queue of expected
// head words. Flag expectations are derived from the scoreboard occupancy.
`timescale 1ns/1ps
module tb_scfifo_s_showahead;
  localparam int W  = 16;
  localparam int LD = 4;
  localparam int NW = 15;
  localparam int AF = 12;
  localparam int AE = 2;

  logic         clock  = 1'b0;
  logic         aclr_n = 1'b0;
  logic         sclr   = 1'b0;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q = '0;

  scfifo_s_showahead_if #(.WIDTH(W), .LOG_DEPTH(LD)) fif();

  scfifo_s_showahead #(
    .WIDTH(W), .LOG_DEPTH(LD), .NUM_WORDS(NW),
    .ALMOST_FULL_VALUE(AF), .ALMOST_EMPTY_VALUE(AE)
  ) dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .fif(fif)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Occupancy and threshold flags expected from the scoreboard size
  task automatic chk_flags(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_usedw"}, 32'(fif.usedw), n);
    chk({tag, "_full"},  32'(fif.full),  (n == NW) ? 1 : 0);
    chk({tag, "_af"},    32'(fif.almost_full),  (n >= AF) ? 1 : 0);
    chk({tag, "_ae"},    32'(fif.almost_empty), (n < AE) ? 1 : 0);
  endtask

  // Head word must be visible and match the scoreboard before a pop edge
  task automatic pop_chk(input string tag);
    chk({tag, "_empty"}, 32'(fif.empty), 0);
    chk({tag, "_q"}, 32'(fif.q), 32'(exp_q[0]));
    last_q = exp_q.pop_front();
  endtask

  initial begin
    fif.data  = '0;
    fif.wrreq = 1'b0;
    fif.rdreq = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    // Reset state
    chk("rst_empty", 32'(fif.empty), 1);
    chk("rst_q", 32'(fif.q), 0);
    chk_flags("rst");
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
    chk("rst_ovf", 32'(fif.overflow), 0);
    chk("rst_unf", 32'(fif.underflow), 0);
`endif
    #3 aclr_n = 1'b1;
    tick();

    // Fill latency: one write becomes visible after two further edges
    fif.wrreq = 1'b1; fif.data = 16'h0001; exp_q.push_back(16'h0001);
    tick();
    fif.wrreq = 1'b0;
    chk("lat_e0_empty", 32'(fif.empty), 1);
    chk_flags("lat_e0");
    tick();
    chk("lat_e1_empty", 32'(fif.empty), 1);
    chk_flags("lat_e1");
    tick();
    chk("lat_e2_q", 32'(fif.q), 16'h0001);
    fif.rdreq = 1'b1; pop_chk("lat_pop");
    tick();
    fif.rdreq = 1'b0;
    chk("lat_post_empty", 32'(fif.empty), 1);
    chk_flags("lat_post");

    // Fill to full, then a rejected write
    for (int i = 0; i < 15; i++) begin
      fif.wrreq = 1'b1; fif.data = W'(i); exp_q.push_back(W'(i));
      tick();
      chk_flags($sformatf("fill%0d", i));
    end
    fif.data = 16'hBEEF;
    tick();
    fif.wrreq = 1'b0;
    chk_flags("ovf");
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
    chk("ovf_flag", 32'(fif.overflow), 1);
`endif
    tick(); tick();
    chk("full_q", 32'(fif.q), 0);

    // Full with simultaneous write and pop: only the pop lands
    fif.wrreq = 1'b1; fif.data = 16'hDEAD; fif.rdreq = 1'b1;
    pop_chk("fullrw");
    tick();
    fif.wrreq = 1'b0; fif.rdreq = 1'b0;
    chk("fullrw_q", 32'(fif.q), 16'h0001);
    chk_flags("fullrw");

    // Drain: 0xBEEF and 0xDEAD must never appear
    while (exp_q.size() > 0) begin
      fif.rdreq = 1'b1; pop_chk("drain");
      tick();
      chk_flags("drain");
    end
    fif.rdreq = 1'b0;
    chk("drain_empty", 32'(fif.empty), 1);
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
    chk("ovf_sticky", 32'(fif.overflow), 1);
`endif

    // Underflow: pops on an empty FIFO change nothing
    for (int i = 0; i < 3; i++) begin
      fif.rdreq = 1'b1;
      tick();
      chk("unf_empty", 32'(fif.empty), 1);
      chk("unf_q", 32'(fif.q), 32'(last_q));
      chk_flags("unf");
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
      chk("unf_flag", 32'(fif.underflow), 1);
`endif
    end
    fif.rdreq = 1'b0;

    // Streaming 200 words with concurrent write/pop after the first three
    for (int i = 0; i < 3; i++) begin
      fif.wrreq = 1'b1; fif.data = W'(16'h1000 + i); exp_q.push_back(W'(16'h1000 + i));
      tick();
    end
    for (int i = 3; i < 200; i++) begin
      fif.wrreq = 1'b1; fif.data = W'(16'h1000 + i);
      fif.rdreq = 1'b1; pop_chk("stream");
      exp_q.push_back(W'(16'h1000 + i));
      tick();
      chk_flags("stream");
    end
    fif.wrreq = 1'b0;
    while (exp_q.size() > 0) begin
      fif.rdreq = 1'b1; pop_chk("stream_drain");
      tick();
    end
    fif.rdreq = 1'b0;
    chk("stream_end_empty", 32'(fif.empty), 1);
    chk_flags("stream_end");

    // Synchronous clear with 7 words held
    for (int i = 0; i < 7; i++) begin
      fif.wrreq = 1'b1; fif.data = W'(16'h2000 + i); exp_q.push_back(W'(16'h2000 + i));
      tick();
    end
    fif.wrreq = 1'b0;
    tick(); tick();
    chk_flags("pre_sclr");
    chk("pre_sclr_q", 32'(fif.q), 16'h2000);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    exp_q.delete();
    chk("sclr_empty", 32'(fif.empty), 1);
    chk("sclr_q", 32'(fif.q), 0);
    chk_flags("sclr");
`ifdef SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN
    chk("sclr_ovf", 32'(fif.overflow), 0);
    chk("sclr_unf", 32'(fif.underflow), 0);
`endif
    fif.wrreq = 1'b1; fif.data = 16'h3000; exp_q.push_back(16'h3000);
    tick();
    fif.wrreq = 1'b0;
    tick(); tick();
    fif.rdreq = 1'b1; pop_chk("sclr_first");
    tick();
    fif.rdreq = 1'b0;
    chk("sclr_first_empty", 32'(fif.empty), 1);

    // Asynchronous clear mid-cycle during a fill
    for (int i = 0; i < 4; i++) begin
      fif.wrreq = 1'b1; fif.data = W'(16'h4000 + i); exp_q.push_back(W'(16'h4000 + i));
      tick();
    end
    chk("pre_aclr_q", 32'(fif.q), 16'h4000);
    fif.data = 16'h4004;
    #2 aclr_n = 1'b0;
    #1;
    exp_q.delete();
    chk("aclr_empty", 32'(fif.empty), 1);
    chk("aclr_q", 32'(fif.q), 0);
    chk_flags("aclr");
    @(posedge clock);
    #2 fif.wrreq = 1'b0;
    #1 aclr_n = 1'b1;
    tick();
    chk("aclr_hold_empty", 32'(fif.empty), 1);
    chk_flags("aclr_hold");
    fif.wrreq = 1'b1; fif.data = 16'h5000; exp_q.push_back(16'h5000);
    tick();
    fif.wrreq = 1'b0;
    tick(); tick();
    fif.rdreq = 1'b1; pop_chk("aclr_first");
    tick();
    fif.rdreq = 1'b0;
    chk("aclr_first_empty", 32'(fif.empty), 1);
    chk_flags("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scfifo_s_showahead.md
Name: scfifo_s_showahead

Overview:
- Single-clock show-ahead (first-word-fall-through) FIFO. This is the next generation of the team's normal-mode scfifo_s.
- Head word is presented on q whenever empty is low; rdreq acknowledges and pops it.
- Generalised depth (MLAB or M20K-sized).
- Always-on overflow/underflow protection.
- Two-stage prefetch pipeline that hides the synchronous memory read latency.
- Target use: streaming datapaths that need data valid without a read-request round trip.

Parameters:
- WIDTH, 16, data width in bits (>=1).
- LOG_DEPTH, 4, address width of storage array; valid 3..10, else $error at elaboration.
- NUM_WORDS, 2**LOG_DEPTH-1, max words held, including prefetch stages; valid 1..2**LOG_DEPTH-1.
- ALMOST_FULL_VALUE, 12, almost_full threshold; valid 1..NUM_WORDS.
- ALMOST_EMPTY_VALUE, 2, almost_empty threshold; valid 1..NUM_WORDS.

Ports:
- clock  in  1  rising-edge clock.
- aclr_n  in  1  asynchronous reset, active-low.
- sclr  in  1  synchronous clear, active-high.
- data  in  WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read acknowledge: pops q.
- q  out  WIDTH  head-of-FIFO data; valid when empty=0.
- usedw  out  LOG_DEPTH  words accepted and not yet popped.
- empty  out  1  no word visible on q.
- full  out  1  usedw==NUM_WORDS.
- almost_empty  out  1  usedw<ALMOST_EMPTY_VALUE.
- almost_full  out  1  usedw>=ALMOST_FULL_VALUE.

Behaviour:
- Reset values:
  - aclr_n=0, asynchronous, highest priority. All pointers, usedw, and stage-valid bits cleared; q=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - sclr=1 at an edge gives the same values synchronously.
  - Reset mid-operation discards all contents, including in-flight prefetch words.
- Accept rules:
  - Write accepted iff wrreq=1 and full=0.
  - Pop accepted iff rdreq=1 and empty=0.
  - Rejected requests change no state.
- Simultaneous events:
  - full=1 with both requests: only the pop is accepted; full falls after the edge.
  - empty=1 with both requests: only the write is accepted.
- Storage:
  - Array of 2**LOG_DEPTH words with a synchronous read.
  - Write and read pointers wrap modulo 2**LOG_DEPTH.
  - Prefetch pipeline: memory read register (stage 1), then output register (stage 2) driving q.
  - A word leaves the array when it is fetched into stage 1.
- Write-to-visible latency:
  - Write accepted at edge k into an otherwise empty FIFO: stage 1 loads at k+1, q and empty=0 valid after edge k+2.
  - No write-to-q bypass.
- Throughput:
  - Once non-empty, sustains 1 pop/cycle with concurrent 1 write/cycle indefinitely, with no bubbles on q.
  - Fetch rule: fetch into stage 1 whenever the array is non-empty and stage 1 will be free or is draining into stage 2 at this edge.
- Pop behaviour: after an accepted pop at edge k, q shows the next word after edge k, or empty=1 if no word is in stage 1.
- usedw:
  - Registered. usedw_next = usedw + acc_wr - acc_rd, with LOG_DEPTH-bit arithmetic that never wraps (bounded by NUM_WORDS).
  - Counts in-flight words, so usedw=1 or 2 with empty=1 is legal during the 2-cycle fill.
- Flags:
  - full, almost_full and almost_empty are registered.
  - Each is computed from usedw_next, so it is coherent with usedw in the same cycle.
  - empty is registered and equals NOT(stage-2 valid).
- Order: strict FIFO order; no word duplicated or lost across pointer wrap.

Optional Feature:
- Macro SCFIFO_S_SHOWAHEAD_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow and underflow (each 1 bit).
  - overflow sets at the edge after wrreq=1 while full=1.
  - underflow sets at the edge after rdreq=1 while empty=1.
  - Both are sticky until aclr_n=0 or sclr=1; reset value 0.
- Undefined: ports and logic are absent; rejected requests are silently dropped.

Test Plan:
- Reset/fill latency:
  - Stimulus: aclr_n low, then release; write 0x0001 at edge 0, then idle.
  - Response: empty=1 after edges 0..1; q=0x0001 and empty=0 after edge 2; usedw=1 from edge 0.
- Fill to full (defaults):
  - Stimulus: write 0x0000..0x000E on 15 consecutive edges, then a 16th write of 0xBEEF.
  - Response: almost_full=1 when usedw=12; full=1 at usedw=15; 0xBEEF dropped.
  - With the macro defined: overflow=1.
- Full with simultaneous wr+rd:
  - Stimulus: from full, assert both wrreq and rdreq for one edge.
  - Response: q advances 0x0000 to 0x0001, usedw=14, full=0; written word not stored.
- Streaming and order:
  - Stimulus: 200 words, incrementing pattern, concurrent wr/rd after the first 3.
  - Response: q sequence matches exactly, with no empty gaps after first valid; pointers wrap at least 10 times.
- Underflow:
  - Stimulus: empty FIFO, rdreq=1 for 3 edges.
  - Response: usedw stays 0, q unchanged, empty=1; with the macro defined, underflow=1 and sticky.
- Mid-operation clears:
  - Stimulus: usedw=7, then sclr pulse; later, async aclr_n low mid-cycle during a fill.
  - Response: both give empty=1, usedw=0, almost_empty=1, q=0 immediately; the next written word is the first popped.
